// File: rtl/seg7_pkg.sv
// seg7_pkg -- shared seven-segment definitions.
// Purpose : holds the hex-digit segment table (bit 0 = a ... bit 6 = g,
//           active-high) and the segment index constants, plus a small
//           lookup helper used by the decoder.
// Ports   : none (package).
package seg7_pkg;

  localparam int SEG_W = 7;

  // Segment index constants, seg[SEG_A] is segment a.
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Element 0 is the leftmost entry, so the table reads in hex order 0..F.
  localparam logic [0:15][SEG_W-1:0] SEG_TABLE = {
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [SEG_W-1:0] seg7_lookup(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/hex_scan_counter_if.sv
// hex_scan_counter_if -- control/status bundle of the hex scan counter.
// Purpose : groups every non-clock, non-reset signal of hex_scan_counter.
// Signals : run, up_dn, load, load_val, div_max, manual, manual_val
//           (driven by the master); count, tick, wrap, seg, dig_en
//           (driven by the counter, the slave side).
interface hex_scan_counter_if
  import seg7_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int DIV_W  = 12
);

  logic                  run;
  logic                  up_dn;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [DIV_W-1:0]      div_max;
  logic                  manual;
  logic [4*DIGITS-1:0]   manual_val;
  logic [4*DIGITS-1:0]   count;
  logic                  tick;
  logic                  wrap;
  logic [SEG_W-1:0]      seg;
  logic [DIGITS-1:0]     dig_en;

  modport master (
    output run, up_dn, load, load_val, div_max, manual, manual_val,
    input  count, tick, wrap, seg, dig_en
  );

  modport slave (
    input  run, up_dn, load, load_val, div_max, manual, manual_val,
    output count, tick, wrap, seg, dig_en
  );

endinterface

// File: rtl/seg7_decode.sv
// seg7_decode -- combinational hex nibble to seven-segment decoder.
// Ports : nibble in  4  hex digit value
//         seg    out 7  segments, active-high, seg[0]=a ... seg[6]=g
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0]         nibble,
  output logic [SEG_G:SEG_A] seg
);

  assign seg = seg7_lookup(nibble);

endmodule

// File: rtl/hex_scan_counter.sv
// hex_scan_counter -- prescaled up/down hex counter with multiplexed
// seven-segment display scan.
// Ports : clk  in  single clock, all flops on its rising edge
//         rst  in  asynchronous, active-high reset
//         bus  slave side of hex_scan_counter_if:
//              run/up_dn/load/load_val  counter control
//              div_max                  prescaler terminal count
//              manual/manual_val        display source override
//              count/tick/wrap          counter status
//              seg/dig_en               registered display scan outputs
module hex_scan_counter
  import seg7_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int DIV_W  = 12,
  parameter int SCAN_W = 8
) (
  input logic               clk,
  input logic               rst,
  hex_scan_counter_if.slave bus
);

  localparam int CW    = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [DIV_W-1:0]  p_reg, p_next;
  logic              tick_reg, tick_next;
  logic [CW-1:0]     count_reg, count_next, count_step;
  logic              wrap_reg, wrap_next;
  logic [SCAN_W-1:0] s_reg;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [CW-1:0]     disp_val;
  logic [3:0]        nib [DIGITS];
  logic [3:0]        nib_sel;
  logic [SEG_W-1:0]  seg_dec, seg_reg;
  logic [DIGITS-1:0] dig_en_next, dig_en_reg;

  // Prescaler and counter. The terminal compare registers tick, and the
  // counter steps on the edge that closes a tick cycle, so wrap lands in
  // the cycle right after the step. Load wins over everything.
  always_comb begin
    p_next    = p_reg + DIV_W'(1);
    tick_next = 1'b0;
    if (p_reg == bus.div_max) begin
      p_next    = '0;
      tick_next = 1'b1;
    end

    count_step = bus.up_dn ? count_reg + CW'(1) : count_reg - CW'(1);
    count_next = count_reg;
    wrap_next  = 1'b0;

    if (bus.load) begin
      count_next = bus.load_val;
      p_next     = '0;
      tick_next  = 1'b0;
    end else if (tick_reg && bus.run) begin
      count_next = count_step;
      wrap_next  = bus.up_dn ? (&count_reg) : (count_reg == '0);
    end
  end

  // Digit index advances whenever the free-running scan counter rolls over.
  always_comb begin
    idx_next = idx_reg;
    if (&s_reg) begin
      if (idx_reg == IDX_W'(DIGITS - 1)) begin
        idx_next = '0;
      end else begin
        idx_next = idx_reg + IDX_W'(1);
      end
    end
  end

  assign disp_val = bus.manual ? bus.manual_val : count_reg;

  // Digit 0 is the least-significant nibble.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign nib[gi]         = disp_val[4*gi +: 4];
      assign dig_en_next[gi] = (idx_reg == IDX_W'(gi));
    end
  endgenerate

  // Explicit compare chain keeps the select in range for any DIGITS.
  always_comb begin
    nib_sel = nib[0];
    for (int i = 1; i < DIGITS; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        nib_sel = nib[i];
      end
    end
  end

  seg7_decode u_decode (
    .nibble (nib_sel),
    .seg    (seg_dec)
  );

  // seg and dig_en are captured together from the same digit index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_reg      <= '0;
      tick_reg   <= 1'b0;
      count_reg  <= '0;
      wrap_reg   <= 1'b0;
      s_reg      <= '0;
      idx_reg    <= '0;
      seg_reg    <= '0;
      dig_en_reg <= DIGITS'(1);
    end else begin
      p_reg      <= p_next;
      tick_reg   <= tick_next;
      count_reg  <= count_next;
      wrap_reg   <= wrap_next;
      s_reg      <= s_reg + SCAN_W'(1);
      idx_reg    <= idx_next;
      seg_reg    <= seg_dec;
      dig_en_reg <= dig_en_next;
    end
  end

  assign bus.count  = count_reg;
  assign bus.tick   = tick_reg;
  assign bus.wrap   = wrap_reg;
  assign bus.seg    = seg_reg;
  assign bus.dig_en = dig_en_reg;

endmodule

// File: tb/tb_hex_scan_counter.sv
// tb_hex_scan_counter -- scoreboard bench for hex_scan_counter.
// Two instances (DIGITS=2 and DIGITS=1, SCAN_W=2, DIV_W=4) share one
// stimulus stream. A reference model predicts every cycle's outputs and
// pushes them into per-instance queues; a monitor on the falling edge pops
// and compares.
module tb_hex_scan_counter;

  localparam int DIV_W  = 4;
  localparam int SCAN_W = 2;

  typedef struct {
    logic [7:0] count;
    logic       tick;
    logic       wrap;
    logic [6:0] seg;
    logic [1:0] dig_en;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       run, up_dn, load, manual;
  logic [7:0] load_val, manual_val;
  logic [3:0] div_max;

  int n_vec  = 0;
  int n_miss = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t mon_e;

  // Segment encodings for hex 0..F.
  logic [6:0] seg_ref [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                               7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                               7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model state.
  int m_p, m_tick, m_n;
  int m_cnt [2];
  int m_wrap [2];

  always #5 clk = ~clk;

  hex_scan_counter_if #(.DIGITS(2), .DIV_W(DIV_W)) bus2 ();
  hex_scan_counter_if #(.DIGITS(1), .DIV_W(DIV_W)) bus1 ();

  assign bus2.run        = run;
  assign bus2.up_dn      = up_dn;
  assign bus2.load       = load;
  assign bus2.load_val   = load_val;
  assign bus2.div_max    = div_max;
  assign bus2.manual     = manual;
  assign bus2.manual_val = manual_val;

  assign bus1.run        = run;
  assign bus1.up_dn      = up_dn;
  assign bus1.load       = load;
  assign bus1.load_val   = load_val[3:0];
  assign bus1.div_max    = div_max;
  assign bus1.manual     = manual;
  assign bus1.manual_val = manual_val[3:0];

  hex_scan_counter #(.DIGITS(2), .DIV_W(DIV_W), .SCAN_W(SCAN_W)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  hex_scan_counter #(.DIGITS(1), .DIV_W(DIV_W), .SCAN_W(SCAN_W)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_p    = 0;
    m_tick = 0;
    m_n    = 0;
    for (int k = 0; k < 2; k++) begin
      m_cnt[k]  = 0;
      m_wrap[k] = 0;
    end
  endtask

  // Advance the model across one rising edge using the inputs present at
  // that edge, then queue the outputs expected after it.
  task automatic model_edge();
    exp_t e;
    int   old_tick, digs, modv, disp, idx, nv;
    old_tick = m_tick;
    if (load) begin
      m_p    = 0;
      m_tick = 0;
    end else if (m_p == int'(div_max)) begin
      m_p    = 0;
      m_tick = 1;
    end else begin
      m_p    = (m_p + 1) % (1 << DIV_W);
      m_tick = 0;
    end
    for (int k = 0; k < 2; k++) begin
      digs     = (k == 0) ? 2 : 1;
      modv     = 1 << (4 * digs);
      disp     = manual ? (int'(manual_val) % modv) : m_cnt[k];
      idx      = (m_n >> SCAN_W) % digs;
      e.seg    = seg_ref[(disp >> (4 * idx)) & 15];
      e.dig_en = 2'(1 << idx);
      if (load) begin
        m_cnt[k]  = int'(load_val) % modv;
        m_wrap[k] = 0;
      end else if (old_tick == 1 && run) begin
        nv        = m_cnt[k] + (up_dn ? 1 : -1);
        m_wrap[k] = (nv < 0 || nv >= modv) ? 1 : 0;
        m_cnt[k]  = (nv + modv) % modv;
      end else begin
        m_wrap[k] = 0;
      end
      e.count = 8'(m_cnt[k]);
      e.tick  = (m_tick != 0);
      e.wrap  = (m_wrap[k] != 0);
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    m_n++;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic check_reset();
    chk("rst_count2",  16'(bus2.count),  16'h0);
    chk("rst_tick2",   16'(bus2.tick),   16'h0);
    chk("rst_wrap2",   16'(bus2.wrap),   16'h0);
    chk("rst_seg2",    16'(bus2.seg),    16'h0);
    chk("rst_dig_en2", 16'(bus2.dig_en), 16'h1);
    chk("rst_count1",  16'(bus1.count),  16'h0);
    chk("rst_seg1",    16'(bus1.seg),    16'h0);
    chk("rst_dig_en1", 16'(bus1.dig_en), 16'h1);
  endtask

  // Reset pulse placed between the falling edge and the next rising edge.
  task automatic mid_reset();
    #5;
    rst = 1'b1;
    #1;
    check_reset();
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Monitor: one expected entry per instance per cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        mon_e = q0.pop_front();
        chk("count2",  16'(bus2.count),  16'(mon_e.count));
        chk("tick2",   16'(bus2.tick),   16'(mon_e.tick));
        chk("wrap2",   16'(bus2.wrap),   16'(mon_e.wrap));
        chk("seg2",    16'(bus2.seg),    16'(mon_e.seg));
        chk("dig_en2", 16'(bus2.dig_en), 16'(mon_e.dig_en));
      end
      if (q1.size() > 0) begin
        mon_e = q1.pop_front();
        chk("count1",  16'(bus1.count),  16'(mon_e.count));
        chk("tick1",   16'(bus1.tick),   16'(mon_e.tick));
        chk("wrap1",   16'(bus1.wrap),   16'(mon_e.wrap));
        chk("seg1",    16'(bus1.seg),    16'(mon_e.seg));
        chk("dig_en1", 16'(bus1.dig_en), 16'(1'b1));
      end
    end
  end

  initial begin
    int waited;
    rst        = 1'b0;
    run        = 1'b1;
    up_dn      = 1'b1;
    load       = 1'b0;
    load_val   = 8'h00;
    div_max    = 4'd3;
    manual     = 1'b0;
    manual_val = 8'h00;

    // Reset takes effect before any clock edge.
    #2;
    rst = 1'b1;
    #1;
    check_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    $display("phase reset: outputs checked at reset");

    // div_max=3 counting up: tick every 4th cycle.
    run_cycles(20);
    $display("phase count_up: 20 cycles, div_max=3");

    // Load FF then count up through the wrap, then down through 00.
    load_val = 8'hFF;
    load     = 1'b1;
    cycle();
    load = 1'b0;
    run_cycles(12);
    up_dn = 1'b0;
    run_cycles(16);
    up_dn = 1'b1;
    $display("phase wrap: load FF, up wrap, down wrap");

    // Load while tick is high.
    waited = 0;
    while (m_tick != 1 && waited < 40) begin
      cycle();
      waited++;
    end
    chk("wait_tick", 16'(m_tick), 16'h1);
    load_val = 8'h5A;
    load     = 1'b1;
    cycle();
    load = 1'b0;
    run_cycles(10);
    $display("phase load_on_tick: load 5A during tick");

    // Manual display of 3C while the counter keeps running.
    manual     = 1'b1;
    manual_val = 8'h3C;
    run_cycles(16);
    // Sweep every nibble value through both digit positions.
    for (int v = 0; v < 16; v++) begin
      manual_val = {4'(v), 4'(15 - v)};
      run_cycles(8);
    end
    manual = 1'b0;
    $display("phase manual: 3C and 16-nibble sweep");

    // Prescaler corners: every-cycle tick, max period, shrink below p.
    div_max = 4'd0;
    run_cycles(10);
    div_max = 4'd15;
    run_cycles(10);
    div_max = 4'd2;
    run_cycles(24);
    $display("phase prescaler: div_max 0, 15, shrink to 2");

    // Frozen count with prescaler still ticking.
    run = 1'b0;
    run_cycles(15);
    run = 1'b1;
    $display("phase freeze: run=0 for 15 cycles");

    // Asynchronous reset while count holds A7.
    load_val = 8'hA7;
    load     = 1'b1;
    run      = 1'b0;
    cycle();
    load = 1'b0;
    run_cycles(2);
    chk("pre_rst_count", 16'(bus2.count), 16'hA7);
    mid_reset();
    run     = 1'b1;
    div_max = 4'd3;
    run_cycles(14);
    $display("phase mid_reset: reset from A7, resumed");

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      run = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) up_dn = ~up_dn;
      load     = ($urandom_range(0, 31) == 0);
      load_val = 8'($urandom);
      if ($urandom_range(0, 63) == 0) begin
        div_max = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                              : 4'($urandom_range(0, 4));
      end
      if ($urandom_range(0, 31) == 0) manual = ~manual;
      if ($urandom_range(0, 7) == 0) manual_val = 8'($urandom);
      cycle();
      if ($urandom_range(0, 299) == 0) mid_reset();
    end
    load = 1'b0;
    $display("phase random: 1500 cycles");

    @(negedge clk);
    #1;
    chk("drain_q0", 16'(q0.size()), 16'h0);
    chk("drain_q1", 16'(q1.size()), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
